// File: rtl/nn_train_sequencer.sv
// rtl/nn_train_sequencer.sv - stimulus sequencer feeding weights and dataset samples to the NN training core
module nn_train_sequencer #(
    parameter int DATA_W        = 32,
    parameter int EPOCH_MAX     = 24,
    parameter int DATASET_MAX   = 99,
    parameter int EPOCH_WIDTH   = $clog2(EPOCH_MAX),
    parameter int DATASET_WIDTH = $clog2(DATASET_MAX),
    parameter int D_WORDS       = 4,
    parameter int W1_NUM        = 12,
    parameter int W2_NUM        = 3,
    parameter int ADDR_W        = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [1:0]               wr_sel,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     start,
    input  logic                     nn_out_valid,
    output logic [EPOCH_WIDTH-1:0]   epoch,
    output logic [DATASET_WIDTH-1:0] dataset_index,
    output logic                     in_valid_d,
    output logic                     in_valid_t,
    output logic                     in_valid_w1,
    output logic                     in_valid_w2,
    output logic [DATA_W-1:0]        data_point,
    output logic [DATA_W-1:0]        target,
    output logic [DATA_W-1:0]        weight1,
    output logic [DATA_W-1:0]        weight2,
    output logic                     busy,
    output logic                     done,
    output logic                     proto_err
);
    localparam int D_TOTAL  = (DATASET_MAX + 1) * D_WORDS;
    localparam int CNT_W    = $clog2(W1_NUM);
    localparam int W2_IDX_W = $clog2(W2_NUM);

    typedef enum logic [2:0] {IDLE, SEND_W1, SEND_W2, SEND_D, WAIT_OUT, FINISH} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [EPOCH_WIDTH-1:0]   ep, ep_nxt;
    logic [DATASET_WIDTH-1:0] idx, idx_nxt;
    logic [ADDR_W-1:0]        d_addr;

    logic [DATA_W-1:0] data_mem   [D_TOTAL];
    logic [DATA_W-1:0] target_mem [DATASET_MAX+1];
    logic [DATA_W-1:0] w1_mem     [W1_NUM];
    logic [DATA_W-1:0] w2_mem     [W2_NUM];

    assign d_addr = ADDR_W'(idx) * ADDR_W'(D_WORDS) + ADDR_W'(cnt);

    // Loads land only while idle; out-of-range addresses are dropped silently.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en && state == IDLE) begin
            case (wr_sel)
                2'd0: if (wr_addr < ADDR_W'(D_TOTAL)) data_mem[wr_addr] <= wr_data;
                2'd1: if (wr_addr <= ADDR_W'(DATASET_MAX)) target_mem[wr_addr[DATASET_WIDTH-1:0]] <= wr_data;
                2'd2: if (wr_addr < ADDR_W'(W1_NUM)) w1_mem[wr_addr[CNT_W-1:0]] <= wr_data;
                default: if (wr_addr < ADDR_W'(W2_NUM)) w2_mem[wr_addr[W2_IDX_W-1:0]] <= wr_data;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ep_nxt    = ep;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SEND_W1;
                    cnt_nxt   = '0;
                    ep_nxt    = '0;
                    idx_nxt   = '0;
                end
            end
            SEND_W1: begin
                if (cnt == CNT_W'(W1_NUM - 1)) begin
                    state_nxt = SEND_W2;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SEND_W2: begin
                if (cnt == CNT_W'(W2_NUM - 1)) begin
                    state_nxt = SEND_D;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SEND_D: begin
                if (cnt == CNT_W'(D_WORDS - 1)) begin
                    state_nxt = WAIT_OUT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WAIT_OUT: begin
                if (nn_out_valid) begin
                    if (idx != DATASET_WIDTH'(DATASET_MAX)) begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = SEND_D;
                    end else if (ep != EPOCH_WIDTH'(EPOCH_MAX)) begin
                        idx_nxt   = '0;
                        ep_nxt    = ep + 1'b1;
                        state_nxt = SEND_D;
                    end else begin
                        idx_nxt   = '0;
                        ep_nxt    = '0;
                        state_nxt = FINISH;
                    end
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            ep            <= '0;
            idx           <= '0;
            epoch         <= '0;
            dataset_index <= '0;
            in_valid_d    <= 1'b0;
            in_valid_t    <= 1'b0;
            in_valid_w1   <= 1'b0;
            in_valid_w2   <= 1'b0;
            data_point    <= '0;
            target        <= '0;
            weight1       <= '0;
            weight2       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ep    <= ep_nxt;
            idx   <= idx_nxt;
            if ((wr_en && state != IDLE) || (nn_out_valid && state != WAIT_OUT))
                proto_err <= 1'b1;
            in_valid_w1   <= (state == SEND_W1);
            weight1       <= (state == SEND_W1) ? w1_mem[cnt] : '0;
            in_valid_w2   <= (state == SEND_W2);
            weight2       <= (state == SEND_W2) ? w2_mem[cnt[W2_IDX_W-1:0]] : '0;
            in_valid_d    <= (state == SEND_D);
            data_point    <= (state == SEND_D) ? data_mem[d_addr] : '0;
            in_valid_t    <= (state == SEND_D) && (cnt == '0);
            target        <= ((state == SEND_D) && (cnt == '0)) ? target_mem[idx] : '0;
            epoch         <= ep;
            dataset_index <= idx;
            busy          <= (state != IDLE) && (state != FINISH);
            done          <= (state == FINISH);
        end
    end
endmodule

// File: tb/tb_nn_train_sequencer.sv
// tb/tb_nn_train_sequencer.sv - scoreboard bench for nn_train_sequencer
module tb_nn_train_sequencer;
    localparam int DATA_W = 32, EPOCH_MAX = 24, DATASET_MAX = 99, EW = 5, DW = 7;
    localparam int D_WORDS = 4, W1_NUM = 12, W2_NUM = 3, ADDR_W = 9;
    localparam int NS = DATASET_MAX + 1;
    localparam int SAMPLES = (EPOCH_MAX + 1) * NS;

    typedef struct {
        logic [3:0]        v;      // {w1, w2, d, t}
        logic [DATA_W-1:0] w1, w2, d, t;
        logic [EW-1:0]     ep;
        logic [DW-1:0]     ix;
        bit                contig;
        int                mark;   // 1 = first weight1 beat, 2 = first data beat
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, wr_en = 1'b0, start = 1'b0;
    logic [1:0] wr_sel = '0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic resp_valid = 1'b0, inj_valid = 1'b0;
    logic nn_out_valid;
    logic [EW-1:0] epoch;
    logic [DW-1:0] dataset_index;
    logic in_valid_d, in_valid_t, in_valid_w1, in_valid_w2, busy, done, proto_err;
    logic [DATA_W-1:0] data_point, target, weight1, weight2;

    assign nn_out_valid = resp_valid | inj_valid;

    nn_train_sequencer dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .nn_out_valid(nn_out_valid), .epoch(epoch),
        .dataset_index(dataset_index), .in_valid_d(in_valid_d), .in_valid_t(in_valid_t),
        .in_valid_w1(in_valid_w1), .in_valid_w2(in_valid_w2), .data_point(data_point),
        .target(target), .weight1(weight1), .weight2(weight2), .busy(busy), .done(done),
        .proto_err(proto_err)
    );

    logic [DATA_W-1:0] m_data [NS*D_WORDS];
    logic [DATA_W-1:0] m_tgt  [NS];
    logic [DATA_W-1:0] m_w1   [W1_NUM];
    logic [DATA_W-1:0] m_w2   [W2_NUM];

    beat_t exp_q[$];
    int cyc = 0;
    int errors = 0, checks = 0;
    int done_cnt = 0, t_total = 0, first_w1_cyc = -1, first_d_cyc = -1, last_beat_cyc = -10;
    int run_id = 0, long_run = -1, t_start = 0;
    bit fast = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic model_write(input int sel, input int addr, input logic [DATA_W-1:0] val);
        case (sel)
            0: if (addr < NS * D_WORDS) m_data[addr] = val;
            1: if (addr <= DATASET_MAX) m_tgt[addr] = val;
            2: if (addr < W1_NUM) m_w1[addr] = val;
            default: if (addr < W2_NUM) m_w2[addr] = val;
        endcase
    endtask

    task automatic write(input int sel, input int addr, input logic [DATA_W-1:0] val);
        wr_en = 1'b1; wr_sel = 2'(sel); wr_addr = ADDR_W'(addr); wr_data = val;
        model_write(sel, addr, val);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Expected stream of one full run: weights once, then every sample of every epoch.
    task automatic push_run();
        beat_t b;
        for (int i = 0; i < W1_NUM; i++) begin
            b = '{v: 4'b1000, w1: m_w1[i], w2: 0, d: 0, t: 0, ep: 0, ix: 0,
                  contig: (i > 0), mark: (i == 0) ? 1 : 0};
            exp_q.push_back(b);
        end
        for (int i = 0; i < W2_NUM; i++) begin
            b = '{v: 4'b0100, w1: 0, w2: m_w2[i], d: 0, t: 0, ep: 0, ix: 0, contig: 1'b1, mark: 0};
            exp_q.push_back(b);
        end
        for (int e = 0; e <= EPOCH_MAX; e++)
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < D_WORDS; w++) begin
                    b.v = (w == 0) ? 4'b0011 : 4'b0010;
                    b.w1 = 0; b.w2 = 0;
                    b.d = m_data[s*D_WORDS + w];
                    b.t = (w == 0) ? m_tgt[s] : 0;
                    b.ep = EW'(e); b.ix = DW'(s);
                    b.contig = (w > 0) || (e == 0 && s == 0);
                    b.mark = (e == 0 && s == 0 && w == 0) ? 2 : 0;
                    exp_q.push_back(b);
                end
    endtask

    task automatic do_start(input int hold);
        start = 1'b1;
        @(posedge clk); #1;
        t_start = cyc;
        wr_en = 1'b0;
        if (hold <= 1) start = 1'b0;
        @(negedge clk);
        chk(busy == 1'b0, "busy_low_in_start_cycle", busy, 0);
        @(posedge clk); #1;
        if (hold <= 2) start = 1'b0;
        @(negedge clk);
        chk(busy == 1'b1, "busy_high_after_start", busy, 1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_latency();
        repeat (20) @(posedge clk);
        #1;
        chk(first_w1_cyc == t_start + 1, "w1_latency", first_w1_cyc, t_start + 1);
        chk(first_d_cyc == t_start + W1_NUM + W2_NUM + 1, "d_latency", first_d_cyc, t_start + W1_NUM + W2_NUM + 1);
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(done_cnt != d0, "done_within_budget", n, budget);
    endtask

    task automatic wait_sample(input int ep_want, input int ix_want, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(in_valid_t && epoch == EW'(ep_want) && dataset_index == DW'(ix_want)) && n < budget);
        chk(n < budget, "reach_sample", n, budget);
    endtask

    task automatic abort_run();
        int d0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        run_id++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        chk({epoch, dataset_index, in_valid_d, in_valid_t, in_valid_w1, in_valid_w2, busy, done, proto_err} == '0,
            "abort_ctrl_zero", {epoch, dataset_index, in_valid_d, in_valid_t, in_valid_w1, in_valid_w2, busy, done, proto_err}, 0);
        chk((data_point | target | weight1 | weight2) == '0, "abort_bus_zero", data_point | target | weight1 | weight2, 0);
        repeat (20) @(posedge clk);
        #1;
        chk(done_cnt == d0, "no_done_after_abort", done_cnt, d0);
    endtask

    // Monitor: pop and compare on every presented beat.
    initial begin
        beat_t e;
        logic [3:0] v;
        forever begin
            @(negedge clk);
            v = {in_valid_w1, in_valid_w2, in_valid_d, in_valid_t};
            if (v != 4'b0) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", v, 0);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (v != e.v || weight1 != e.w1 || weight2 != e.w2 || data_point != e.d || target != e.t
                        || epoch != e.ep || dataset_index != e.ix) begin
                        errors++;
                        $display("FAIL beat: got v=%b w1=%h w2=%h d=%h t=%h ep=%0d ix=%0d expected v=%b w1=%h w2=%h d=%h t=%h ep=%0d ix=%0d",
                                 v, weight1, weight2, data_point, target, epoch, dataset_index,
                                 e.v, e.w1, e.w2, e.d, e.t, e.ep, e.ix);
                    end
                    if (e.contig) chk(cyc == last_beat_cyc + 1, "beat_contiguous", cyc, last_beat_cyc + 1);
                    if (e.mark == 1) first_w1_cyc = cyc;
                    if (e.mark == 2) first_d_cyc = cyc;
                end
                last_beat_cyc = cyc;
                if (in_valid_t) t_total++;
            end else begin
                chk((data_point | target | weight1 | weight2) == '0, "idle_bus_zero", data_point | target | weight1 | weight2, 0);
            end
            if (done) begin
                done_cnt++;
                chk(!busy && exp_q.size() == 0 && epoch == '0 && dataset_index == '0, "done_state",
                    {busy, epoch, dataset_index, 16'(exp_q.size())}, 0);
            end
        end
    end

    // Core model: answers each sample after a random delay (one very long wait in the first run).
    initial begin
        int dcount = 0;
        int my_id, dly;
        bit stable;
        logic [EW-1:0] e0;
        logic [DW-1:0] i0;
        logic p0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dcount = 0;
            end else if (in_valid_d) begin
                dcount++;
                if (dcount == D_WORDS) begin
                    dcount = 0;
                    my_id = run_id;
                    if (my_id == long_run && epoch == '0 && dataset_index == DW'(5)) begin
                        stable = 1'b1; e0 = epoch; i0 = dataset_index; p0 = proto_err;
                        repeat (1000) begin
                            @(negedge clk);
                            if ({in_valid_w1, in_valid_w2, in_valid_d, in_valid_t} != 4'b0 ||
                                epoch != e0 || dataset_index != i0 || proto_err != p0)
                                stable = 1'b0;
                        end
                        chk(stable, "long_wait_stable", {epoch, dataset_index, proto_err}, {e0, i0, p0});
                    end else begin
                        dly = fast ? $urandom_range(0, 2) : $urandom_range(0, 7);
                        repeat (dly) @(posedge clk);
                    end
                    @(posedge clk); #1;
                    if (my_id == run_id) resp_valid = 1'b1;
                    @(posedge clk); #1;
                    resp_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d0;
        logic [DATA_W-1:0] x;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk({epoch, dataset_index, in_valid_d, in_valid_t, in_valid_w1, in_valid_w2, busy, done, proto_err} == '0,
            "reset_ctrl_zero", {epoch, dataset_index, busy, done, proto_err}, 0);
        chk((data_point | target | weight1 | weight2) == '0, "reset_bus_zero", data_point | target | weight1 | weight2, 0);

        for (int i = 0; i < NS * D_WORDS; i++) write(0, i, DATA_W'(i));
        for (int i = 0; i < NS; i++) write(1, i, DATA_W'(i));
        for (int i = 0; i < W1_NUM; i++) write(2, i, DATA_W'(i + 1));
        for (int i = 0; i < W2_NUM; i++) write(3, i, 32'h3F80_0000);

        // Run A: plain run with random response delays and one 1000-cycle stall.
        fast = 1'b0;
        long_run = run_id;
        push_run();
        t0 = t_total;
        do_start(1);
        check_latency();
        wait_done(40000);
        chk(t_total - t0 == SAMPLES, "run_a_samples", t_total - t0, SAMPLES);
        chk(proto_err == 1'b0, "run_a_no_error", proto_err, 0);
        chk(busy == 1'b0, "run_a_idle", busy, 0);

        // Run B: ignored out-of-range loads, random reloads, write+start together, start held 3 cycles.
        write(1, NS, 32'hBAD0_0100);
        write(0, NS * D_WORDS, 32'hBAD0_0190);
        write(2, W1_NUM, 32'hBAD0_000C);
        write(3, W2_NUM, 32'hBAD0_0003);
        write(1, 511, 32'hBAD0_01FF);
        repeat (40) write($urandom_range(0, 3), $urandom_range(0, 120), $urandom);
        x = $urandom;
        wr_en = 1'b1; wr_sel = 2'd2; wr_addr = '0; wr_data = x;
        model_write(2, 0, x);
        push_run();
        fast = 1'b1;
        t0 = t_total;
        d0 = done_cnt;
        do_start(3);
        inj_valid = 1'b1;
        @(posedge clk); #1;
        inj_valid = 1'b0;
        @(negedge clk);
        chk(proto_err == 1'b1, "proto_err_on_early_out_valid", proto_err, 1);
        check_latency();
        wr_en = 1'b1; wr_sel = 2'd0; wr_addr = '0; wr_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        wr_sel = 2'd1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_done(40000);
        chk(t_total - t0 == SAMPLES, "run_b_samples", t_total - t0, SAMPLES);
        chk(proto_err == 1'b1, "proto_err_sticky", proto_err, 1);
        repeat (30) @(posedge clk);
        #1;
        chk(done_cnt == d0 + 1, "single_run_for_held_start", done_cnt, d0 + 1);
        chk(busy == 1'b0, "idle_after_run_b", busy, 0);

        // Run C: abort by reset during epoch 3.
        push_run();
        do_start(1);
        wait_sample(3, $urandom_range(0, DATASET_MAX), 20000);
        abort_run();

        // Run D: rerun from the start with the retained memory, then abort.
        push_run();
        t0 = t_total;
        do_start(1);
        check_latency();
        wait_sample(0, 2, 2000);
        abort_run();
        chk(t_total - t0 == 3, "rerun_samples", t_total - t0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
